// File: rtl/cache_mem_arbiter.sv
// Shares one RAM port between single-word icache fetches and locked multi-beat dcache transfers.
// Define ARB_PERF_EN to add saturating grant/stall counters on perf_igrants/perf_dgrants/perf_stalls.
module cache_mem_arbiter #(
  parameter int BURST_LEN  = 2,
  parameter int STARVE_MAX = 4,
  parameter int ADDR_W     = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic              iwait,
  output logic [ADDR_W-1:0] iload,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [ADDR_W-1:0] dstore,
  output logic              dwait,
  output logic [ADDR_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [ADDR_W-1:0] ramstore,
  input  logic [ADDR_W-1:0] ramload,
  input  logic [1:0]        ramstate
`ifdef ARB_PERF_EN
  ,
  output logic [31:0]       perf_igrants,
  output logic [31:0]       perf_dgrants,
  output logic [31:0]       perf_stalls
`endif
);

  localparam int BEAT_W   = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int STARVE_W = $clog2(STARVE_MAX + 1);
  localparam logic [1:0] RAM_ACCESS = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_D = 2'd1,
    GNT_I = 2'd2
  } state_t;

  state_t              state;
  logic [BEAT_W-1:0]   beat_cnt;
  logic [STARVE_W-1:0] starve_cnt;

  logic d_req, ram_access, d_beat, i_beat, d_last, starve_hit;
  logic grant_i, grant_d;

  assign d_req      = dREN | dWEN;
  assign ram_access = (ramstate == RAM_ACCESS);
  assign d_beat     = (state == GNT_D) && d_req && ram_access;
  assign i_beat     = (state == GNT_I) && iREN && ram_access;
  assign d_last     = d_beat && (beat_cnt == BEAT_W'(BURST_LEN - 1));
  assign starve_hit = (starve_cnt == STARVE_W'(STARVE_MAX));

  // A starved icache overrides the normal dcache-first priority.
  assign grant_i = (state == IDLE) && iREN && (starve_hit || !d_req);
  assign grant_d = (state == IDLE) && d_req && !(iREN && starve_hit);

  // NOTE: every register here uses <= so all updates see the same pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      beat_cnt   <= '0;
      starve_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_i)      state <= GNT_I;
          else if (grant_d) state <= GNT_D;
        end
        GNT_D: begin
          if (!d_req || d_last) begin
            state    <= IDLE;
            beat_cnt <= '0;
          end else if (d_beat) begin
            beat_cnt <= beat_cnt + BEAT_W'(1);
          end
        end
        GNT_I: begin
          if (!iREN || i_beat) state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (!iREN || grant_i)
        starve_cnt <= '0;
      else if (state != GNT_I && !starve_hit)
        starve_cnt <= starve_cnt + STARVE_W'(1);
    end
  end

  // RAM-side signals follow the granted requester combinationally so a beat costs no extra cycle.
  always_comb begin
    // NOTE: defaults first so no output is left unassigned on any path (no latches).
    iwait    = 1'b1;
    dwait    = 1'b1;
    iload    = '0;
    dload    = '0;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    case (state)
      GNT_D: begin
        ramaddr  = daddr;
        ramstore = dstore;
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        dload    = ramload;
        dwait    = ~ram_access;
      end
      GNT_I: begin
        ramaddr = iaddr;
        ramREN  = iREN;
        iload   = ramload;
        iwait   = ~ram_access;
      end
      default: ;
    endcase
  end

`ifdef ARB_PERF_EN
  logic [31:0] i_grants, d_grants, stall_cycles;
  logic        any_req, stalled;

  assign any_req = iREN | d_req;
  assign stalled = any_req && !(d_beat || i_beat);

  always_ff @(posedge CLK) begin
    if (RST) begin
      i_grants     <= '0;
      d_grants     <= '0;
      stall_cycles <= '0;
    end else begin
      if (grant_i && i_grants != '1)     i_grants     <= i_grants + 32'd1;
      if (grant_d && d_grants != '1)     d_grants     <= d_grants + 32'd1;
      if (stalled && stall_cycles != '1) stall_cycles <= stall_cycles + 32'd1;
    end
  end

  assign perf_igrants = i_grants;
  assign perf_dgrants = d_grants;
  assign perf_stalls  = stall_cycles;
`endif

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Bench for cache_mem_arbiter: directed arbitration scenarios plus randomized concurrent traffic
// checked against a shadow memory and the arbitration rules; ARB_PERF_EN adds counter checks.
module tb_cache_mem_arbiter;

  localparam int BURST_LEN  = 2;
  localparam int STARVE_MAX = 4;
  localparam int ADDR_W     = 32;
  localparam logic [1:0] R_FREE = 2'd0, R_BUSY = 2'd1, R_ACCESS = 2'd2;

  logic              CLK = 1'b0;
  logic              RST = 1'b1;
  logic              iREN = 1'b0;
  logic [ADDR_W-1:0] iaddr = '0;
  logic              iwait;
  logic [ADDR_W-1:0] iload;
  logic              dREN = 1'b0;
  logic              dWEN = 1'b0;
  logic [ADDR_W-1:0] daddr = '0;
  logic [ADDR_W-1:0] dstore = '0;
  logic              dwait;
  logic [ADDR_W-1:0] dload;
  logic              ramREN, ramWEN;
  logic [ADDR_W-1:0] ramaddr, ramstore, ramload;
  logic [1:0]        ramstate;
`ifdef ARB_PERF_EN
  logic [31:0]       perf_igrants, perf_dgrants, perf_stalls;
`endif

  cache_mem_arbiter #(
    .BURST_LEN (BURST_LEN),
    .STARVE_MAX(STARVE_MAX),
    .ADDR_W    (ADDR_W)
  ) dut (
    .CLK     (CLK),
    .RST     (RST),
    .iREN    (iREN),
    .iaddr   (iaddr),
    .iwait   (iwait),
    .iload   (iload),
    .dREN    (dREN),
    .dWEN    (dWEN),
    .daddr   (daddr),
    .dstore  (dstore),
    .dwait   (dwait),
    .dload   (dload),
    .ramREN  (ramREN),
    .ramWEN  (ramWEN),
    .ramaddr (ramaddr),
    .ramstore(ramstore),
    .ramload (ramload),
    .ramstate(ramstate)
`ifdef ARB_PERF_EN
    ,
    .perf_igrants(perf_igrants),
    .perf_dgrants(perf_dgrants),
    .perf_stalls (perf_stalls)
`endif
  );

  always #5 CLK = ~CLK;

  // RAM model: a strobed request sees `lat` BUSY cycles, then one ACCESS cycle per word.
  logic [31:0] ram_mem [256];
  logic [31:0] shadow  [256];
  logic        ram_init = 1'b1;
  int          lat = 0;
  int          ram_cnt = 0;
  logic        in_burst = 1'b0;

  function automatic logic [31:0] init_word(input int i);
    return {8'hC3, i[7:0], 16'(i * 37)};
  endfunction

  always_comb begin
    if (!(ramREN | ramWEN)) ramstate = R_FREE;
    else if (ram_cnt >= lat) ramstate = R_ACCESS;
    else                     ramstate = R_BUSY;
  end

  assign ramload = ram_mem[ramaddr[9:2]];

  always @(posedge CLK) begin
    if (ram_init) begin
      for (int i = 0; i < 256; i++) ram_mem[i] <= init_word(i);
      ram_cnt <= 0;
    end else if (ramstate == R_ACCESS) begin
      if (ramWEN) ram_mem[ramaddr[9:2]] <= ramstore;
      ram_cnt <= 0;
    end else if (ramREN | ramWEN) begin
      ram_cnt <= ram_cnt + 1;
    end else begin
      ram_cnt <= 0;
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Returns at the negedge of the completing beat; cyc = cycles waited, -1 on timeout.
  task automatic wait_beat(input bit for_i, input string tag, output int cyc);
    cyc = -1;
    for (int n = 0; n < 100; n++) begin
      @(negedge CLK);
      if ((for_i && !iwait) || (!for_i && !dwait)) begin
        cyc = n;
        break;
      end
      step();
    end
    if (cyc < 0) check({tag, "_timeout"}, 32'd1, 32'd0);
  endtask

  task automatic icache_fetch(input logic [31:0] a);
    int cyc;
    iREN  = 1'b1;
    iaddr = a;
    wait_beat(1'b1, "ifetch", cyc);
    if (cyc >= 0) begin
      check("ifetch_data", iload, shadow[a[9:2]]);
      check("ifetch_no_split", {31'b0, in_burst}, 32'd0);
    end
    step();
    iREN = 1'b0;
  endtask

  task automatic dcache_burst(input logic [31:0] base, input bit wr);
    logic [31:0] a, wd;
    int  beat;
    bit  lock_chk;
    beat = 0;
    lock_chk = 1'b0;
    a = base;
    wd = $urandom;
    dWEN = wr;
    dREN = wr ? 1'($urandom_range(0, 1)) : 1'b1;
    daddr = a;
    dstore = wd;
    for (int n = 0; n < 200 && beat < BURST_LEN; n++) begin
      @(negedge CLK);
      if (lock_chk) begin
        check("dburst_locked", {31'b0, ramREN | ramWEN}, 32'd1);
        lock_chk = 1'b0;
      end
      if (!dwait) begin
        if (wr) shadow[a[9:2]] = wd;
        else    check("dburst_data", dload, shadow[a[9:2]]);
        beat++;
        in_burst = (beat < BURST_LEN);
        step();
        if (beat < BURST_LEN) begin
          a = a + 32'd4;
          wd = $urandom;
          daddr = a;
          dstore = wd;
          lock_chk = 1'b1;
        end
      end else begin
        step();
      end
    end
    dREN = 1'b0;
    dWEN = 1'b0;
    in_burst = 1'b0;
    if (beat < BURST_LEN) check("dburst_timeout", 32'd1, 32'd0);
  endtask

`ifdef ARB_PERF_EN
  bit perf_on = 1'b0;
  int bench_stalls = 0;
  always @(negedge CLK) begin
    if (perf_on && (iREN | dREN | dWEN) &&
        !((!iwait && iREN) || (!dwait && (dREN | dWEN))))
      bench_stalls++;
  end
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int cyc, ilow, dbeats, got_ic, exp_ic, dcount;
    bit dhit;
    logic [31:0] a;

    for (int i = 0; i < 256; i++) shadow[i] = init_word(i);

    // ---------------- reset state ----------------
    RST = 1'b1;
    repeat (3) step();
    ram_init = 1'b0;
    @(negedge CLK);
    check("rst_ramREN", {31'b0, ramREN}, 32'd0);
    check("rst_ramWEN", {31'b0, ramWEN}, 32'd0);
    check("rst_iwait", {31'b0, iwait}, 32'd1);
    check("rst_dwait", {31'b0, dwait}, 32'd1);
    check("rst_ramaddr", ramaddr, 32'd0);
    check("rst_ramstore", ramstore, 32'd0);
    check("rst_iload", iload, 32'd0);
    check("rst_dload", dload, 32'd0);
    step();
    RST = 1'b0;
    step();

    // ---------------- contention: dcache wins, icache after the dead cycle ----------------
    lat = 2;
    step();
    iREN = 1'b1; iaddr = 32'h10;
    dREN = 1'b1; daddr = 32'h100;
    ilow = 0;
    dbeats = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge CLK);
      if (c == 0) check("cont_grant_latency", {31'b0, ramREN}, 32'd0);
      if (c == 1) begin
        check("cont_d_first_ren", {31'b0, ramREN}, 32'd1);
        check("cont_d_first_addr", ramaddr, 32'h100);
      end
      if (!iwait) ilow++;
      if (!dwait) begin
        a = daddr;
        check("cont_dbeat_cycle", c, (dbeats == 0) ? 32'd3 : 32'd6);
        check("cont_dload", dload, shadow[a[9:2]]);
        dbeats++;
      end
      if (c == 7) check("cont_dead_cycle", {31'b0, ramREN}, 32'd0);
      step();
      if (c == 3) daddr = 32'h104;
      if (c == 6) dREN = 1'b0;
    end
    check("cont_dbeats", dbeats, 32'd2);
    check("cont_iwait_high", ilow, 32'd0);
    @(negedge CLK);
    check("cont_i_grant_ren", {31'b0, ramREN}, 32'd1);
    check("cont_i_grant_addr", ramaddr, 32'h10);
    step();
    wait_beat(1'b1, "cont_i", cyc);
    check("cont_i_latency", cyc, 32'd1);
    a = 32'h10;
    check("cont_iload", iload, shadow[a[9:2]]);
    step();
    iREN = 1'b0;
    repeat (2) step();

    // ---------------- starvation: icache forced in while dcache streams ----------------
    // With zero RAM latency each dcache lock lasts BURST_LEN cycles plus one IDLE, so IDLE
    // falls on cycles 0, BURST_LEN+1, ...; starve count at IDLE cycle k is k (iREN high from 0).
    exp_ic = -1;
    for (int k = 0; exp_ic < 0 && k < 100; k += BURST_LEN + 1)
      if (k >= STARVE_MAX) exp_ic = k + 1;
    lat = 0;
    iREN = 1'b1; iaddr = 32'h24;
    dREN = 1'b1; dWEN = 1'b0; daddr = 32'h140;
    got_ic = -1;
    dcount = 0;
    for (int c = 0; c < 30 && got_ic < 0; c++) begin
      @(negedge CLK);
      dhit = !dwait;
      if (dhit) begin
        a = daddr;
        check("starve_dload", dload, shadow[a[9:2]]);
        dcount++;
      end
      if (!iwait) begin
        got_ic = c;
        a = iaddr;
        check("starve_iload", iload, shadow[a[9:2]]);
        check("starve_dren_high", {31'b0, dREN}, 32'd1);
      end
      step();
      if (dhit) daddr = daddr + 32'd4;
    end
    iREN = 1'b0;
    dREN = 1'b0;
    check("starve_icycle", got_ic, exp_ic);
    check("starve_dbeats", dcount, ((exp_ic - 1) / (BURST_LEN + 1)) * BURST_LEN);
    repeat (2) step();

    // ---------------- write priority ----------------
    lat = 1;
    dREN = 1'b1; dWEN = 1'b1; daddr = 32'h200; dstore = 32'hDEADBEEF;
    @(negedge CLK);
    step();
    @(negedge CLK);
    check("wr_ramWEN", {31'b0, ramWEN}, 32'd1);
    check("wr_ramREN", {31'b0, ramREN}, 32'd0);
    check("wr_ramaddr", ramaddr, 32'h200);
    check("wr_ramstore", ramstore, 32'hDEADBEEF);
    step();
    wait_beat(1'b0, "wr_beat0", cyc);
    a = 32'h200;
    shadow[a[9:2]] = 32'hDEADBEEF;
    step();
    daddr = 32'h204; dstore = 32'h0BADF00D;
    wait_beat(1'b0, "wr_beat1", cyc);
    a = 32'h204;
    shadow[a[9:2]] = 32'h0BADF00D;
    step();
    dREN = 1'b0; dWEN = 1'b0;
    step();
    a = 32'h200;
    check("wr_ram_word", ram_mem[a[9:2]], 32'hDEADBEEF);
    dcache_burst(32'h200, 1'b0);
    step();

    // ---------------- early release ----------------
    lat = 1;
    iREN = 1'b1; iaddr = 32'h30;
    dREN = 1'b1; daddr = 32'h180;
    wait_beat(1'b0, "early_d", cyc);
    a = 32'h180;
    check("early_dload", dload, shadow[a[9:2]]);
    step();
    dREN = 1'b0;
    @(negedge CLK);
    check("early_drop_no_strobe", {31'b0, ramREN | ramWEN}, 32'd0);
    step();
    @(negedge CLK);
    check("early_idle_ren", {31'b0, ramREN}, 32'd0);
    check("early_idle_iwait", {31'b0, iwait}, 32'd1);
    step();
    @(negedge CLK);
    check("early_i_grant_ren", {31'b0, ramREN}, 32'd1);
    check("early_i_grant_addr", ramaddr, 32'h30);
    step();
    wait_beat(1'b1, "early_i", cyc);
    a = 32'h30;
    check("early_iload", iload, shadow[a[9:2]]);
    step();
    iREN = 1'b0;
    dcache_burst(32'h188, 1'b0);
    step();

    // ---------------- reset during a BUSY dcache beat ----------------
    lat = 3;
    dREN = 1'b1; daddr = 32'h1C0;
    @(negedge CLK);
    step();
    @(negedge CLK);
    check("rstmid_granted", {31'b0, ramREN}, 32'd1);
    step();
    RST = 1'b1;
    @(negedge CLK);
    check("rstmid_no_partial", {31'b0, dwait}, 32'd1);
    step();
    @(negedge CLK);
    check("rstmid_ramREN", {31'b0, ramREN}, 32'd0);
    check("rstmid_ramWEN", {31'b0, ramWEN}, 32'd0);
    check("rstmid_iwait", {31'b0, iwait}, 32'd1);
    check("rstmid_dwait", {31'b0, dwait}, 32'd1);
    step();
    RST = 1'b0;
    dREN = 1'b0;
    repeat (2) step();

    // ---------------- randomized concurrent traffic ----------------
    for (int round = 0; round < 3; round++) begin
      lat = $urandom_range(0, 2);
      step();
      fork
        begin
          for (int k = 0; k < 12; k++) begin
            repeat ($urandom_range(0, 3)) step();
            icache_fetch(32'($urandom_range(0, 63)) << 2);
          end
        end
        begin
          for (int k = 0; k < 10; k++) begin
            repeat ($urandom_range(0, 3)) step();
            dcache_burst(32'h100 + (32'($urandom_range(0, 95)) << 3), 1'($urandom_range(0, 1)));
          end
        end
      join
      repeat (2) step();
    end

`ifdef ARB_PERF_EN
    // ---------------- performance counters ----------------
    lat = 1;
    RST = 1'b1;
    repeat (2) step();
    RST = 1'b0;
    perf_on = 1'b1;
    for (int k = 0; k < 3; k++) icache_fetch(32'(k) << 2);
    for (int k = 0; k < 2; k++) begin
      step();
      dcache_burst(32'h300 + (32'(k) << 3), 1'b0);
    end
    repeat (2) step();
    perf_on = 1'b0;
    @(negedge CLK);
    check("perf_igrants", perf_igrants, 32'd3);
    check("perf_dgrants", perf_dgrants, 32'd2);
    check("perf_stalls", perf_stalls, bench_stalls);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
